// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate-generation stage: format selector codes
// and their width. The RVC formats (8-15) are built only with IMM_GEN_RVC_EN.
package imm_gen_pkg;

  localparam int IMM_OP_W = 4;

  localparam logic [IMM_OP_W-1:0] IMM_I     = 4'd0;
  localparam logic [IMM_OP_W-1:0] IMM_S     = 4'd1;
  localparam logic [IMM_OP_W-1:0] IMM_B     = 4'd2;
  localparam logic [IMM_OP_W-1:0] IMM_J     = 4'd3;
  localparam logic [IMM_OP_W-1:0] IMM_U     = 4'd4;
  localparam logic [IMM_OP_W-1:0] IMM_Z     = 4'd5;
  localparam logic [IMM_OP_W-1:0] IMM_SH    = 4'd6;
  localparam logic [IMM_OP_W-1:0] IMM_ZERO  = 4'd7;
  localparam logic [IMM_OP_W-1:0] IMM_CI    = 4'd8;
  localparam logic [IMM_OP_W-1:0] IMM_CJ    = 4'd9;
  localparam logic [IMM_OP_W-1:0] IMM_CB    = 4'd10;
  localparam logic [IMM_OP_W-1:0] IMM_CIW   = 4'd11;
  localparam logic [IMM_OP_W-1:0] IMM_CLS   = 4'd12;
  localparam logic [IMM_OP_W-1:0] IMM_CLWSP = 4'd13;
  localparam logic [IMM_OP_W-1:0] IMM_CSWSP = 4'd14;
  localparam logic [IMM_OP_W-1:0] IMM_CLUI  = 4'd15;

  // Compressed formats occupy the upper half of the selector space.
  function automatic logic imm_op_is_rvc(input logic [IMM_OP_W-1:0] op);
    return op[IMM_OP_W-1];
  endfunction

endpackage

// File: rtl/imm_gen_comb.sv
// Pure combinational immediate decode. Everything is built 64 bits wide and
// truncated to XLEN. RVC arms exist only when IMM_GEN_RVC_EN is defined.
module imm_gen_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]         inst,
  input  logic [IMM_OP_W-1:0] op,
  output logic [XLEN-1:0]     imm,
  output logic                err
);

  logic [63:0] wide;
  logic        unused_bits;

  always_comb begin
    wide = '0;
    err  = 1'b0;
    case (op)
      IMM_I:    wide = {{52{inst[31]}}, inst[31:20]};
      IMM_S:    wide = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:    wide = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:    wide = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_U:    wide = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_Z:    wide = {59'b0, inst[19:15]};
      // RV64 shifts take a 6-bit amount; RV32 only the low five bits.
      IMM_SH:   wide = (XLEN == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
      IMM_ZERO: wide = '0;
`ifdef IMM_GEN_RVC_EN
      IMM_CI:    wide = {{58{inst[12]}}, inst[12], inst[6:2]};
      IMM_CJ:    wide = {{52{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                         inst[2], inst[11], inst[5:3], 1'b0};
      IMM_CB:    wide = {{55{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                         inst[4:3], 1'b0};
      IMM_CIW:   wide = {54'b0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b0};
      IMM_CLS:   wide = {57'b0, inst[5], inst[12:10], inst[6], 2'b0};
      IMM_CLWSP: wide = {56'b0, inst[3:2], inst[12], inst[6:4], 2'b0};
      IMM_CSWSP: wide = {56'b0, inst[8:7], inst[12:9], 2'b0};
      IMM_CLUI:  wide = {{46{inst[12]}}, inst[12], inst[6:2], 12'b0};
      default:   wide = '0;
`else
      default: begin
        wide = '0;
        err  = imm_op_is_rvc(op);
      end
`endif
    endcase
  end

  assign imm = wide[XLEN-1:0];

  // Opcode bits and the upper half of wide (XLEN=32) are intentionally unused.
  assign unused_bits = ^{wide, inst};

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a one-entry skid buffer, flush
// and sideband tag. Optional RVC formats are enabled by IMM_GEN_RVC_EN.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [IMM_OP_W-1:0] in_op,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_imm,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_err
);

  // Handshake: a beat moves across a port in any cycle where valid && ready
  // are both high at the rising edge. out_valid/out_imm/out_tag/out_err never
  // change while out_valid && !out_ready. in_ready is a pure register output
  // (!skid_valid) with no combinational path from out_ready.

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [TAG_W-1:0] main_tag;
  logic             main_err;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  logic             accept;
  logic             emit;

  imm_gen_comb #(
    .XLEN (XLEN)
  ) u_dec (
    .inst (in_inst),
    .op   (in_op),
    .imm  (dec_imm),
    .err  (dec_err)
  );

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign emit      = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_imm   = main_imm;
  assign out_tag   = main_tag;
  assign out_err   = main_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_tag   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || emit) begin
      // Main is free this cycle: the older skid beat has priority over input.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_imm   <= skid_imm;
        main_tag   <= skid_tag;
        main_err   <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_imm   <= dec_imm;
        main_tag   <= in_tag;
        main_err   <= dec_err;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_tag   <= in_tag;
      skid_err   <= dec_err;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one input
// stream and are checked against an in-order queue of decoded beats.
module tb_imm_gen_stage;

  localparam int TAG_W = 8;
  localparam int EW    = 105; // {err, tag[7:0], imm64[63:0], imm32[31:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [3:0]  in_op = '0;
  logic [7:0]  in_tag = '0;

  logic        rdy32, rdy64, ov32, ov64, err32, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0]  tag32, tag64;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic          after_rst = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_err(err32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_op(in_op), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_err(err64)
  );

  // ---------------- reference model ----------------
  // Immediate value as a signed/unsigned integer, then scaled by its alignment.
  function automatic logic [64:0] ref_imm(input logic [31:0] i, input logic [3:0] op,
                                          input int xlen);
    longint v;
    logic   e;
    v = 0;
    e = 1'b0;
    case (op)
      4'd0: v = longint'($signed(i[31:20]));
      4'd1: v = longint'($signed({i[31:25], i[11:7]}));
      4'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
      4'd3: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
      4'd4: v = longint'($signed(i[31:12])) * 4096;
      4'd5: v = longint'(i[19:15]);
      4'd6: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
      4'd7: v = 0;
      default: begin
`ifdef IMM_GEN_RVC_EN
        case (op)
          4'd8:  v = longint'($signed({i[12], i[6:2]}));
          4'd9:  v = longint'($signed({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3]})) * 2;
          4'd10: v = longint'($signed({i[12], i[6:5], i[2], i[11:10], i[4:3]})) * 2;
          4'd11: v = longint'({i[10:7], i[12:11], i[5], i[6]}) * 4;
          4'd12: v = longint'({i[5], i[12:10], i[6]}) * 4;
          4'd13: v = longint'({i[3:2], i[12], i[6:4]}) * 4;
          4'd14: v = longint'({i[8:7], i[12:9]}) * 4;
          default: v = longint'($signed({i[12], i[6:2]})) * 4096;
        endcase
`else
        v = 0;
        e = 1'b1;
`endif
      end
    endcase
    return {e, 64'(v)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Checks registered outputs at the falling edge, then drives the next beat
  // and advances the model to the state expected after the coming rising edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [3:0] op,
                      input logic [7:0] tag, input logic ordy, input logic fl,
                      input logic rs);
    logic [EW-1:0] f;
    logic [64:0]   r32, r64;
    logic          emit, acc;
    @(negedge clk);
    chk("out_valid32", 64'(ov32), 64'(exp_q.size() > 0));
    chk("out_valid64", 64'(ov64), 64'(exp_q.size() > 0));
    chk("in_ready32", 64'(rdy32), 64'(exp_q.size() < 2));
    chk("in_ready64", 64'(rdy64), 64'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      chk("imm32", 64'(imm32), 64'(f[31:0]));
      chk("imm64", imm64, f[95:32]);
      chk("tag32", 64'(tag32), 64'(f[103:96]));
      chk("tag64", 64'(tag64), 64'(f[103:96]));
      chk("err32", 64'(err32), 64'(f[104]));
      chk("err64", 64'(err64), 64'(f[104]));
    end
    if (after_rst) begin
      chk("rst_imm32", 64'(imm32), 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_tag32", 64'(tag32), 64'd0);
      chk("rst_tag64", 64'(tag64), 64'd0);
      chk("rst_err32", 64'(err32), 64'd0);
      chk("rst_err64", 64'(err64), 64'd0);
    end
    in_valid  = v;
    in_inst   = inst;
    in_op     = op;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    emit = (exp_q.size() > 0) && ordy;
    acc  = v && (exp_q.size() < 2);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (emit) void'(exp_q.pop_front());
      if (acc) begin
        r32 = ref_imm(inst, op, 32);
        r64 = ref_imm(inst, op, 64);
        exp_q.push_back({r64[64], tag, r64[63:0], r32[31:0]});
      end
    end
    after_rst = rs;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 4'd0, 8'h00, ordy, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [31:0] inst, input logic [3:0] op, input logic [7:0] tag,
                      input logic ordy);
    step(1'b1, inst, op, tag, ordy, 1'b0, 1'b0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    after_rst = 1'b1;
    step(1'b0, 32'h0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);   // reset values visible

    // Known encodings, full throughput.
    send(32'hFE000CE3, 4'd2, 8'h11, 1'b1);               // beq -8
    send(32'hFFF00093, 4'd0, 8'h12, 1'b1);
    chk("beq_imm32", 64'(imm32), 64'hFFFF_FFF8);
    send(32'h80000037, 4'd4, 8'h13, 1'b1);
    chk("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
    send(32'h03F00013, 4'd6, 8'h14, 1'b1);               // shamt field = 63
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    send(32'h000050FD, 4'd8, 8'h15, 1'b1);               // c.li x1,-1
    chk("sh_imm64", imm64, 64'h3F);
    chk("sh_imm32", 64'(imm32), 64'h1F);
    idle(1'b1);
`ifdef IMM_GEN_RVC_EN
    chk("cli_imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("cli_err", 64'(err32), 64'd0);
`else
    chk("cli_imm32", 64'(imm32), 64'd0);
    chk("cli_err", 64'(err32), 64'd1);
`endif
    idle(1'b1);

    // Backpressure: tags 1,2 stored, tag 3 stalls, then drains in order.
    send(32'h00100093, 4'd0, 8'd1, 1'b0);
    send(32'h00200093, 4'd0, 8'd2, 1'b0);
    send(32'h00300093, 4'd0, 8'd3, 1'b0);
    send(32'h00300093, 4'd0, 8'd3, 1'b0);
    chk("stall_in_ready", 64'(rdy32), 64'd0);
    chk("stall_tag", 64'(tag32), 64'd1);
    send(32'h00300093, 4'd0, 8'd3, 1'b1);
    send(32'h00300093, 4'd0, 8'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with both registers full and a beat offered.
    send(32'h00A00093, 4'd0, 8'h21, 1'b0);
    send(32'h00B00093, 4'd0, 8'h22, 1'b0);
    step(1'b1, 32'h00C00093, 4'd0, 8'hEE, 1'b0, 1'b1, 1'b0);
    send(32'h00D00093, 4'd0, 8'h23, 1'b1);
    chk("flush_out_valid", 64'(ov32), 64'd0);
    chk("flush_in_ready", 64'(rdy32), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-stream with the consumer stalled, rst and flush together.
    send(32'hFFF00093, 4'd0, 8'h31, 1'b0);
    send(32'h80000037, 4'd4, 8'h32, 1'b0);
    step(1'b1, 32'h12345678, 4'd1, 8'h33, 1'b0, 1'b1, 1'b1);
    idle(1'b1);

    // Randomized traffic with backpressure, occasional flush and reset.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end
    for (int k = 0; k < 4; k++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
